// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the fetch stage of the single-cycle core.
//   br_type_e     : branch type decoded by control (NONE, B, CBZ, B.LT)
//   fetch_state_e : fetch sequencer states (BOOT, FETCH, HOLD)
//   INSTR_BYTES   : PC increment for a sequential fetch
//   N, Z, V, C    : bit positions inside the stored 4-bit flag register
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_NONE   = 2'b00,
    BR_UNCOND = 2'b01,
    BR_CBZ    = 2'b10,
    BR_BLT    = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

  localparam int unsigned N = 3;
  localparam int unsigned Z = 2;
  localparam int unsigned V = 1;
  localparam int unsigned C = 0;

endpackage : cpu_pkg

// File: rtl/instr_fetch_unit_branch_target.sv
// ---------------------------------------------------------------------------
// branch_target
// Combinational branch offset/target generator.
//   pc          : address of the instruction being resolved
//   instruction : held instruction word (imm26 in [25:0], imm19 in [23:5])
//   br_type     : branch type; BR_UNCOND selects imm26, others select imm19
//   offset      : sign-extended word offset, shifted to a byte offset
//   target      : pc + offset, modulo 2^64
// ---------------------------------------------------------------------------
module branch_target
  import cpu_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [31:0] instruction,
  input  br_type_e    br_type,
  output logic [63:0] offset,
  output logic [63:0] target
);

  logic [63:0] br26;
  logic [63:0] br19;

  assign br26 = {{36{instruction[25]}}, instruction[25:0], 2'b00};
  assign br19 = {{43{instruction[23]}}, instruction[23:5], 2'b00};

  assign offset = (br_type == BR_UNCOND) ? br26 : br19;
  assign target = pc + offset;

  // Opcode and condition fields are decoded by control, not here.
  logic unused_fields;
  assign unused_fields = ^{instruction[31:26], instruction[4:0]};

endmodule : branch_target

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the single-cycle datapath: owns the PC and the stored
// condition flags, fetches through a req/valid handshake and holds the word
// until the datapath commits it with `advance`.
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   imem_addr/req           : fetch address (= pc) and request, high in FETCH
//   imem_rdata/valid        : returned word and its strobe
//   instruction/instr_valid : held word to the datapath, valid in HOLD
//   advance                 : datapath commits the held instruction
//   BrType                  : branch type of the held instruction
//   flag_we                 : latch {negative,zero,overflow,carry_out} on advance
//   zero..carry_out         : live ALU flags from the datapath
//   pc, flags               : current PC, stored {N,Z,V,C}
//   fetch_err               : sticky fetch timeout
//
// Build option IMEM_TIMEOUT_EN: after TIMEOUT_CYCLES FETCH cycles without
// imem_valid, set fetch_err, drop imem_req for one cycle (via BOOT) and
// reissue at the same pc. Without it, FETCH waits forever and fetch_err is 0.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'd0,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        advance,
  input  logic [1:0]  BrType,
  input  logic        flag_we,
  input  logic        zero,
  input  logic        negative,
  input  logic        overflow,
  input  logic        carry_out,
  output logic [63:0] pc,
  output logic [3:0]  flags,
  output logic        fetch_err
);

  fetch_state_e state;
  br_type_e     br_type;
  logic [63:0]  br_offset;
  logic [63:0]  br_target;
  logic [63:0]  next_pc;

  assign br_type   = br_type_e'(BrType);
  assign imem_addr = pc;

  branch_target u_branch_target (
    .pc          (pc),
    .instruction (instruction),
    .br_type     (br_type),
    .offset      (br_offset),
    .target      (br_target)
  );

  // B.LT reads the stored flags, so a same-edge flag_we update only affects
  // the following instruction.
  always_comb begin
    // NOTE: default assignment first so every path drives next_pc; no latch.
    next_pc = pc + 64'(INSTR_BYTES);
    unique case (br_type)
      BR_NONE:   ;
      BR_UNCOND: next_pc = br_target;
      BR_CBZ:    if (zero) next_pc = br_target;
      BR_BLT:    if (flags[N] != flags[V]) next_pc = br_target;
      default:   ;
    endcase
  end

`ifdef IMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign fetch_err          = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instruction <= '0;
      flags       <= '0;
`ifdef IMEM_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        // One idle cycle so a response to a pre-reset request is never taken.
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
`ifdef IMEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        FETCH: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
`ifdef IMEM_TIMEOUT_EN
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // BOOT provides the one-cycle request gap before the reissue.
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            wait_cnt  <= '0;
            state     <= BOOT;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end

        HOLD: begin
          if (advance) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
            if (flag_we) flags <= {negative, zero, overflow, carry_out};
`ifdef IMEM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed, self-checking bench for instr_fetch_unit. Inputs change 1 ns
// after the rising edge and outputs are sampled at the same point, well away
// from the active edge. Expected PCs and flags are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        advance;
  logic [1:0]  BrType;
  logic        flag_we;
  logic        zero, negative, overflow, carry_out;
  logic [63:0] pc;
  logic [3:0]  flags;
  logic        fetch_err;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.RESET_PC(64'd0), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .advance     (advance),
    .BrType      (BrType),
    .flag_we     (flag_we),
    .zero        (zero),
    .negative    (negative),
    .overflow    (overflow),
    .carry_out   (carry_out),
    .pc          (pc),
    .flags       (flags),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the first FETCH cycle; returns the word after `lat` cycles.
  task automatic fetch(input logic [31:0] word, input int lat, input string tag);
    for (int i = 1; i < lat; i++) tick();
    imem_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check({tag, "_instr"}, 64'(instruction), 64'(word));
    check({tag, "_ivalid"}, 64'(instr_valid), 64'd1);
  endtask

  // Called in HOLD; commits and checks the address of the following fetch.
  task automatic commit(input logic [1:0] bt, input logic fwe,
                        input logic z, input logic n, input logic v, input logic c,
                        input logic [63:0] exp_pc, input string tag);
    BrType    = bt;
    flag_we   = fwe;
    zero      = z;
    negative  = n;
    overflow  = v;
    carry_out = c;
    advance   = 1'b1;
    tick();
    advance   = 1'b0;
    flag_we   = 1'b0;
    BrType    = 2'b00;
    {zero, negative, overflow, carry_out} = 4'b0000;
    check({tag, "_addr"}, imem_addr, exp_pc);
    check({tag, "_req"}, 64'(imem_req), 64'd1);
  endtask

  initial begin
    reset      = 1'b1;
    imem_rdata = 32'h0;
    imem_valid = 1'b0;
    advance    = 1'b0;
    BrType     = 2'b00;
    flag_we    = 1'b0;
    {zero, negative, overflow, carry_out} = 4'b0000;

    repeat (2) tick();
    check("rst_pc",     pc,                  64'd0);
    check("rst_addr",   imem_addr,           64'd0);
    check("rst_req",    64'(imem_req),       64'd0);
    check("rst_ivalid", 64'(instr_valid),    64'd0);
    check("rst_instr",  64'(instruction),    64'd0);
    check("rst_flags",  64'(flags),          64'd0);
    check("rst_err",    64'(fetch_err),      64'd0);

    // BOOT cycle, then three FETCH cycles with the word on the third.
    reset = 1'b0;
    check("boot_req", 64'(imem_req), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("fetch0_req",  64'(imem_req), 64'd1);
      check("fetch0_addr", imem_addr,     64'd0);
      if (i == 2) begin
        imem_valid = 1'b1;
        imem_rdata = 32'h91001021;
      end
      tick();
    end
    imem_valid = 1'b0;
    check("hold_instr",  64'(instruction), 64'h91001021);
    check("hold_ivalid", 64'(instr_valid), 64'd1);
    check("hold_req",    64'(imem_req),    64'd0);
    repeat (2) tick();
    check("hold_stable", 64'(instruction), 64'h91001021);

    commit(2'b00, 1'b0, 0, 0, 0, 0, 64'h4, "seq");

    fetch(32'h1400000F, 1, "b_fwd");                          // imm26=15
    commit(2'b01, 1'b0, 0, 0, 0, 0, 64'h40, "b_fwd");
    fetch(32'h17FFFFFE, 2, "b_back");                         // imm26=-2
    commit(2'b01, 1'b0, 0, 0, 0, 0, 64'h38, "b_back");
    fetch(32'h17FFFFF4, 1, "b_to8");                          // imm26=-12
    commit(2'b01, 1'b0, 0, 0, 0, 0, 64'h8, "b_to8");

    fetch(32'hB4000060, 1, "cbz_t");                          // imm19=3
    commit(2'b10, 1'b0, 1, 0, 0, 0, 64'h14, "cbz_taken");
    fetch(32'h17FFFFFD, 1, "b_to8b");                         // imm26=-3
    commit(2'b01, 1'b0, 0, 0, 0, 0, 64'h8, "b_to8b");
    fetch(32'hB4000060, 1, "cbz_n");
    commit(2'b10, 1'b0, 0, 0, 0, 0, 64'hC, "cbz_not");

    fetch(32'h14000004, 1, "b_to1c");                         // imm26=4
    commit(2'b01, 1'b0, 0, 0, 0, 0, 64'h1C, "b_to1c");
    fetch(32'hF1000421, 1, "subs");
    commit(2'b00, 1'b1, 0, 1, 0, 0, 64'h20, "subs");
    check("subs_flags", 64'(flags), 64'b1000);

    // Live N/V are 0 here: only the stored flags can make this taken.
    fetch(32'h5400004B, 1, "blt1");                           // imm19=2
    commit(2'b11, 1'b0, 0, 0, 0, 0, 64'h28, "blt_taken");
    check("blt1_flags", 64'(flags), 64'b1000);

    // Same-edge flag write: branch decided on old flags, register updates.
    fetch(32'h5400004B, 1, "blt2");
    commit(2'b11, 1'b1, 1, 0, 0, 1, 64'h30, "blt_same_edge");
    check("blt2_flags", 64'(flags), 64'b0101);
    fetch(32'h5400004B, 1, "blt3");
    commit(2'b11, 1'b0, 0, 0, 0, 0, 64'h34, "blt_not");

    // advance in FETCH is ignored.
    advance = 1'b1; flag_we = 1'b1; BrType = 2'b01; negative = 1'b1;
    tick();
    advance = 1'b0; flag_we = 1'b0; BrType = 2'b00; negative = 1'b0;
    check("ign_adv_addr",   imem_addr,        64'h34);
    check("ign_adv_flags",  64'(flags),       64'b0101);
    check("ign_adv_ivalid", 64'(instr_valid), 64'd0);

`ifdef IMEM_TIMEOUT_EN
    repeat (14) tick();
    check("to_pre_req", 64'(imem_req),  64'd1);
    check("to_pre_err", 64'(fetch_err), 64'd0);
    tick();
    check("to_drop_req", 64'(imem_req),  64'd0);
    check("to_err",      64'(fetch_err), 64'd1);
    tick();
    check("to_reissue_req",  64'(imem_req),  64'd1);
    check("to_reissue_addr", imem_addr,      64'h34);
    check("to_err_sticky",   64'(fetch_err), 64'd1);
`else
    repeat (18) tick();
    check("wait_req",  64'(imem_req),  64'd1);
    check("wait_addr", imem_addr,      64'h34);
    check("wait_err",  64'(fetch_err), 64'd0);
`endif

    // Reset in FETCH; a response arriving during BOOT is dropped.
    reset = 1'b1;
    #1;
    check("rstf_pc",    pc,                 64'd0);
    check("rstf_req",   64'(imem_req),      64'd0);
    check("rstf_flags", 64'(flags),         64'd0);
    check("rstf_err",   64'(fetch_err),     64'd0);
    tick();
    reset      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    check("rstf_boot_req", 64'(imem_req), 64'd0);
    tick();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check("rstf_drop_ivalid", 64'(instr_valid), 64'd0);
    check("rstf_drop_instr",  64'(instruction), 64'd0);
    check("rstf_fetch_req",   64'(imem_req),    64'd1);
    check("rstf_fetch_addr",  imem_addr,        64'd0);

    // Reset in HOLD clears the held word.
    fetch(32'h91001021, 1, "pre_rsth");
    reset = 1'b1;
    #1;
    check("rsth_ivalid", 64'(instr_valid), 64'd0);
    check("rsth_instr",  64'(instruction), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_instr_fetch_unit
